attempt_gate: RTL

Input-conditioning stage directly upstream of the password checker. Synchronises and debounces the raw submit pushbutton and the 16 password switches, and captures a stable 16-bit attempt on each clean press, emitting a one-cycle submit strobe. It consumes the checker's pass/fail verdict, counts consecutive failures, and enforces a timed lockout that blocks further submissions.

---
 rtl/attempt_gate_if.sv | 26 ++
 rtl/attempt_gate.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/attempt_gate_if.sv
// attempt_gate_if: checker-facing bus of the attempt gate.
// The gate (master) publishes the captured attempt, the submit strobe and its
// status flags; the password checker (slave) answers with a verdict strobe.
interface attempt_gate_if #(
    parameter int MAX_FAILS = 3
);
    localparam int FC_W = $clog2(MAX_FAILS + 1);

    logic [15:0]     attempt;
    logic            submit;
    logic            busy;
    logic            locked_out;
    logic [FC_W-1:0] fail_count;
    logic            result_valid;
    logic            result_ok;

    modport master (
        output attempt, submit, busy, locked_out, fail_count,
        input  result_valid, result_ok
    );

    modport slave (
        input  attempt, submit, busy, locked_out, fail_count,
        output result_valid, result_ok
    );
endinterface

// File: rtl/attempt_gate.sv
// attempt_gate: synchronises and debounces the submit key and password
// switches, captures one attempt per clean press, tracks consecutive failed
// verdicts and (optionally) enforces a timed lockout.
// Optional feature: define ATTEMPT_GATE_LOCKOUT_EN to build the LOCKOUT state
// and its timer; without it fail_count saturates at MAX_FAILS and
// locked_out is tied low.
module attempt_gate #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_FAILS       = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 500000000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           key_n,
    input  logic [15:0]    s,
    attempt_gate_if.master bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FC_W = $clog2(MAX_FAILS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_MAX  = FC_W'(MAX_FAILS);

    // Reject parameter values the counters cannot represent.
    if (DEBOUNCE_CYCLES == 0 || MAX_FAILS == 0 || LOCKOUT_CYCLES == 0) begin : g_bad_params
        $error("attempt_gate: DEBOUNCE_CYCLES, MAX_FAILS and LOCKOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_RESULT = 2'd1
`ifdef ATTEMPT_GATE_LOCKOUT_EN
        ,
        LOCKOUT     = 2'd2
`endif
    } state_t;

    logic            key_s1, key_s2;
    logic [15:0]     s_s1, s_s2;
    logic            db_key;
    logic [DB_W-1:0] db_cnt;
    logic            press_evt;

    state_t          state_q, state_d;
    logic [15:0]     attempt_q, attempt_d;
    logic            submit_q, submit_d;
    logic            busy_q;
    logic [FC_W-1:0] fail_q, fail_d;

    // Two-flop synchronisers; the key idles at its released level.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            s_s1   <= '0;
            s_s2   <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            s_s1   <= s;
            s_s2   <= s_s1;
        end
    end

    // Debouncer: accept a new key level after DEBOUNCE_CYCLES consecutive
    // mismatches; flag a press only on the released-to-pressed transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_key    <= 1'b1;
            db_cnt    <= '0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (key_s2 == db_key) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_key    <= key_s2;
                db_cnt    <= '0;
                press_evt <= ~key_s2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

`ifdef ATTEMPT_GATE_LOCKOUT_EN
    localparam logic [31:0] LOCK_LOAD = 32'(LOCKOUT_CYCLES - 1);

    logic [31:0] timer_q, timer_d;
    logic        locked_q;
`endif

    // Next-state and next-output logic for the submit/verdict/lockout FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        attempt_d = attempt_q;
        submit_d  = 1'b0;
        fail_d    = fail_q;
`ifdef ATTEMPT_GATE_LOCKOUT_EN
        timer_d   = timer_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (press_evt) begin
                    attempt_d = s_s2;
                    submit_d  = 1'b1;
                    state_d   = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                // A verdict coinciding with our own submit strobe is stale.
                if (bus.result_valid && !submit_q) begin
                    if (bus.result_ok) begin
                        fail_d  = '0;
                        state_d = IDLE;
                    end else begin
`ifdef ATTEMPT_GATE_LOCKOUT_EN
                        fail_d = fail_q + FC_W'(1);
                        if (fail_d == FC_MAX) begin
                            state_d = LOCKOUT;
                            timer_d = LOCK_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        if (fail_q != FC_MAX) begin
                            fail_d = fail_q + FC_W'(1);
                        end
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef ATTEMPT_GATE_LOCKOUT_EN
            LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; busy is decoded from the next state so it
    // rises with submit and falls on the edge after the verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            attempt_q <= '0;
            submit_q  <= 1'b0;
            busy_q    <= 1'b0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            attempt_q <= attempt_d;
            submit_q  <= submit_d;
            busy_q    <= (state_d == WAIT_RESULT);
            fail_q    <= fail_d;
        end
    end

`ifdef ATTEMPT_GATE_LOCKOUT_EN
    // Lockout timer and registered lockout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            locked_q <= (state_d == LOCKOUT);
        end
    end

    assign bus.locked_out = locked_q;
`else
    assign bus.locked_out = 1'b0;
`endif

    assign bus.attempt    = attempt_q;
    assign bus.submit     = submit_q;
    assign bus.busy       = busy_q;
    assign bus.fail_count = fail_q;

endmodule
